insn_fetch_unit: RTL and testbench
==================================

// Module: insn_fetch_unit
// PURPOSE
//  Fetches 16-bit instructions for the stack-machine execute stage from a word-addressed instruction memory.
//  Maintains the PC and a small instruction FIFO, and presents {insn, pc} to the downstream decoder with a
//  valid/ready handshake. A redirect (jump, pop_pc) from the execute stage flushes the FIFO and drops in-flight fetches.
// PARAMETERS
//  ADDR_W     10  PC / memory word-address width; PC wraps modulo 2**ADDR_W
//  FIFO_DEPTH 4   instruction FIFO entries (power of 2, >=2)
//  RESET_PC   0   PC value loaded on reset
// PORTS
//  clk            in   1       clock, all state on rising edge
//  reset          in   1       synchronous, active-high
//  imem_req_valid out  1       fetch request
//  imem_req_addr  out  ADDR_W  word address of request (= PC)
//  imem_req_ready in   1       memory accepts request this cycle
//  imem_rsp_valid in   1       read data valid, exactly 1 cycle after accepted request
//  imem_rsp_data  in   16      instruction word
//  redirect_valid in   1       execute stage requests PC change
//  redirect_pc    in   ADDR_W  new PC
//  insn_valid     out  1       FIFO head valid
//  insn_data      out  16      FIFO head instruction
//  insn_pc        out  ADDR_W  address of FIFO head instruction
//  insn_ready     in   1       downstream consumes head
// BEHAVIOUR
//  - Reset: pc=RESET_PC, FIFO empty, inflight=0, drop=0; outputs imem_req_valid=0, insn_valid=0,
//    insn_data=0, insn_pc=0. In the first cycle after reset deasserts, imem_req_valid=1 with addr=RESET_PC.
//  - Issue: imem_req_valid = !redirect_valid && (count + inflight < FIFO_DEPTH). Accept = valid&&ready.
//    On accept: pc <= pc+1 (wraps to 0 after 2**ADDR_W-1), inflight <= 1 for the next cycle.
//    At most one request outstanding; 1-cycle accept->response latency permits back-to-back issue.
//  - Response: imem_rsp_valid && !drop -> push {rsp_data, addr of that request} into FIFO. Credit check
//    guarantees the FIFO is never full on push; push into a full FIFO is an assertion failure.
//  - Output: insn_valid = count!=0; insn_data/insn_pc = head entry (registered storage, no comb path from
//    imem_rsp_*). Pop on insn_valid && insn_ready. Push and pop in the same cycle: count unchanged.
//    Pass-through latency: request accept at cycle N, response at N+1, insn_valid at N+2.
//  - Redirect (redirect_valid=1 in cycle N): FIFO cleared at end of N (any pop in N is still counted
//    by downstream, but no push occurs), pc <= redirect_pc, no request issued in N. If a request was
//    accepted in N-1, its response arriving in N is discarded (same cycle); if a request was accepted
//    in N... (impossible, gated). First request from redirect_pc issued in N+1, insn_valid earliest N+3.
//  - Back-to-back redirects: last one wins; each cycle with redirect_valid suppresses issue.
//  - Redirect and reset together: reset wins (pc=RESET_PC).
//  - Reset mid-operation: in-flight response in the cycle after reset is discarded (drop set by reset).
//  - Memory stall (imem_req_ready=0): req_valid and addr held stable until accepted or redirect.
//  - Counters: count is log2(FIFO_DEPTH)+1 bits; rd/wr pointers wrap modulo FIFO_DEPTH.
// TESTING
//  1. Reset, ready=1 always, mem[i]=16'h1000+i, insn_ready=1 -> req addrs 0,1,2..; insn_valid from cycle 2,
//     insn_data 16'h1000,16'h1001.. with insn_pc 0,1,.. one per cycle, no gaps.
//  2. insn_ready=0 -> exactly 4 requests accepted (addrs 0..3), req_valid drops, FIFO holds 4; raise
//     insn_ready -> 4 pops in order, fetch resumes at addr 4 with no loss or duplication.
//  3. Stream running, redirect_valid one cycle with redirect_pc=0x200 -> no insn with pc>=redirect cycle's
//     stale addresses delivered afterwards; next insn_pc=0x200, data mem[0x200], appears 3 cycles later.
//  4. Redirect to 0x3FE, streaming -> insn_pc sequence 0x3FE, 0x3FF, 0x000, 0x001.
//  5. imem_req_ready toggling 1,0,0,1 -> addr held while stalled; FIFO contents in order, no duplicates.
//  6. Assert reset for 1 cycle with FIFO half full and request in flight -> insn_valid=0 next cycle,
//     stale response dropped, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/insn_fetch_unit.sv
// Instruction fetch: PC plus a credit-checked FIFO feeding the decoder.
// Accept at N, response at N+1, insn_valid at N+2. A full FIFO plus the in-flight request stops issue.
module insn_fetch_unit #(
  parameter int                ADDR_W     = 10,
  parameter int                FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req_valid,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_req_ready,
  input  logic              imem_rsp_valid,
  input  logic [15:0]       imem_rsp_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              insn_valid,
  output logic [15:0]       insn_data,
  output logic [ADDR_W-1:0] insn_pc,
  input  logic              insn_ready
);

  localparam int               PTR_W   = $clog2(FIFO_DEPTH);
  localparam int               CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_req_addr;
  logic              r_inflight;

  logic [15:0]       r_fifo_data [FIFO_DEPTH];
  logic [ADDR_W-1:0] r_fifo_pc   [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic [CNT_W-1:0]  w_occupancy;
  logic              w_issue;
  logic              w_accept;
  logic              w_push;
  logic              w_pop;

  // The outstanding request owns a FIFO slot, so its response always fits.
  assign w_occupancy = r_count + CNT_W'(r_inflight);
  assign w_issue     = !reset && !redirect_valid && (w_occupancy < DEPTH_C);
  assign w_accept    = w_issue && imem_req_ready;

  // Only a response to a request accepted last cycle is kept; this also drops
  // anything that arrives just after reset or during a redirect.
  assign w_push      = imem_rsp_valid && r_inflight && !redirect_valid;
  assign w_pop       = insn_valid && insn_ready;

  assign imem_req_valid = w_issue;
  assign imem_req_addr  = r_pc;

  assign insn_valid = (r_count != '0);
  assign insn_data  = r_fifo_data[r_rd_ptr];
  assign insn_pc    = r_fifo_pc[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc       <= RESET_PC;
      r_req_addr <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_accept;
      if (w_accept) begin
        r_req_addr <= r_pc;
      end
      if (redirect_valid) begin
        r_pc <= redirect_pc;
      end else if (w_accept) begin
        r_pc <= r_pc + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo_data[i] <= '0;
        r_fifo_pc[i]   <= '0;
      end
    end else if (redirect_valid) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_fifo_data[r_wr_ptr] <= imem_rsp_data;
        r_fifo_pc[r_wr_ptr]   <= r_req_addr;
        r_wr_ptr              <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && w_push) begin
      a_no_push_when_full: assert (r_count < DEPTH_C);
    end
  end

endmodule

// File: tb/tb_insn_fetch_unit.sv
// Directed vectors for insn_fetch_unit with an in-bench one-cycle instruction memory (mem[a] = 16'h1000 + a).
module tb_insn_fetch_unit;

  logic        clk;
  logic        reset;
  logic        imem_req_valid;
  logic [9:0]  imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [15:0] imem_rsp_data;
  logic        redirect_valid;
  logic [9:0]  redirect_pc;
  logic        insn_valid;
  logic [15:0] insn_data;
  logic [9:0]  insn_pc;
  logic        insn_ready;

  int n_chk = 0;
  int n_err = 0;

  insn_fetch_unit #(.ADDR_W(10), .FIFO_DEPTH(4), .RESET_PC(10'd0)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .insn_valid     (insn_valid),
    .insn_data      (insn_data),
    .insn_pc        (insn_pc),
    .insn_ready     (insn_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        ir;
    logic        mr;
    logic        rv;
    logic [9:0]  rpc;
    logic        rqv;
    logic [9:0]  rqa;
    logic        ci;
    logic        iv;
    logic [15:0] id;
    logic [9:0]  ip;
  } vec_t;

  function automatic vec_t V(input bit rst, input bit ir, input bit mr, input bit rv, input int rpc,
                             input bit rqv, input int rqa, input bit ci, input bit iv,
                             input int id, input int ip);
    vec_t r;
    r.rst = rst; r.ir = ir; r.mr = mr; r.rv = rv; r.rpc = rpc[9:0];
    r.rqv = rqv; r.rqa = rqa[9:0]; r.ci = ci; r.iv = iv;
    r.id = id[15:0]; r.ip = ip[9:0];
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // One clock: remember whether the memory accepted, then answer at the next negedge.
  task automatic tick();
    logic       acc;
    logic [9:0] a;
    acc = imem_req_valid && imem_req_ready;
    a   = imem_req_addr;
    @(posedge clk);
    @(negedge clk);
    imem_rsp_valid = acc;
    imem_rsp_data  = 16'h1000 + {6'd0, a};
    #1;
  endtask

  task automatic step(input vec_t v, input string tag);
    reset          = v.rst;
    insn_ready     = v.ir;
    imem_req_ready = v.mr;
    redirect_valid = v.rv;
    redirect_pc    = v.rpc;
    #1;
    chk($sformatf("%s req_valid", tag), 32'(imem_req_valid), 32'(v.rqv));
    if (v.rqv) chk($sformatf("%s req_addr", tag), 32'(imem_req_addr), 32'(v.rqa));
    if (v.ci) begin
      chk($sformatf("%s insn_valid", tag), 32'(insn_valid), 32'(v.iv));
      if (v.iv) begin
        chk($sformatf("%s insn_data", tag), 32'(insn_data), 32'(v.id));
        chk($sformatf("%s insn_pc", tag), 32'(insn_pc), 32'(v.ip));
      end
    end
    tick();
  endtask

  vec_t tbl[$];

  initial begin
    // streaming from reset, one instruction per cycle
    tbl.push_back(V(0,1,1,0,0, 1,0, 1,0,0,0));
    tbl.push_back(V(0,1,1,0,0, 1,1, 1,0,0,0));
    tbl.push_back(V(0,1,1,0,0, 1,2, 1,1,'h1000,0));
    tbl.push_back(V(0,1,1,0,0, 1,3, 1,1,'h1001,1));
    tbl.push_back(V(0,1,1,0,0, 1,4, 1,1,'h1002,2));
    tbl.push_back(V(1,1,1,0,0, 0,0, 0,0,0,0));
    // downstream stalled: FIFO fills to 4 then drains without loss
    tbl.push_back(V(0,0,1,0,0, 1,0, 1,0,0,0));
    tbl.push_back(V(0,0,1,0,0, 1,1, 1,0,0,0));
    tbl.push_back(V(0,0,1,0,0, 1,2, 1,1,'h1000,0));
    tbl.push_back(V(0,0,1,0,0, 1,3, 1,1,'h1000,0));
    tbl.push_back(V(0,0,1,0,0, 0,4, 1,1,'h1000,0));
    tbl.push_back(V(0,0,1,0,0, 0,4, 1,1,'h1000,0));
    tbl.push_back(V(0,1,1,0,0, 0,4, 1,1,'h1000,0));
    tbl.push_back(V(0,1,1,0,0, 1,4, 1,1,'h1001,1));
    tbl.push_back(V(0,1,1,0,0, 1,5, 1,1,'h1002,2));
    tbl.push_back(V(0,1,1,0,0, 1,6, 1,1,'h1003,3));
    tbl.push_back(V(0,1,1,0,0, 1,7, 1,1,'h1004,4));
    tbl.push_back(V(0,1,1,0,0, 1,8, 1,1,'h1005,5));
    // memory stalls two cycles: address 9 held
    tbl.push_back(V(0,1,0,0,0, 1,9, 1,1,'h1006,6));
    tbl.push_back(V(0,1,0,0,0, 1,9, 1,1,'h1007,7));
    tbl.push_back(V(0,1,1,0,0, 1,9, 1,1,'h1008,8));
    tbl.push_back(V(0,1,1,0,0, 1,10, 1,0,0,0));
    tbl.push_back(V(0,1,1,0,0, 1,11, 1,1,'h1009,9));
    tbl.push_back(V(0,1,1,0,0, 1,12, 1,1,'h100A,10));

    reset = 1'b1; insn_ready = 1'b0; imem_req_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0;

    step(V(1,0,0,0,0, 0,0, 0,0,0,0), "rst0");
    step(V(1,0,0,0,0, 0,0, 0,0,0,0), "rst1");
    chk("reset req_valid", 32'(imem_req_valid), 32'd0);
    chk("reset insn_valid", 32'(insn_valid), 32'd0);
    chk("reset insn_data", 32'(insn_data), 32'd0);
    chk("reset insn_pc", 32'(insn_pc), 32'd0);

    foreach (tbl[i]) step(tbl[i], $sformatf("t%0d", i));

    // single redirect mid-stream: stale response dropped, target appears 3 cycles later
    step(V(0,1,1,1,'h200, 0,0, 1,1,'h100B,11), "redir0");
    step(V(0,1,1,0,0, 1,'h200, 1,0,0,0), "redir1");
    step(V(0,1,1,0,0, 1,'h201, 1,0,0,0), "redir2");
    step(V(0,1,1,0,0, 1,'h202, 1,1,'h1200,'h200), "redir3");
    step(V(0,1,1,0,0, 1,'h203, 1,1,'h1201,'h201), "redir4");

    // PC wrap through the top of the address space
    step(V(0,1,1,1,'h3FE, 0,0, 1,1,'h1202,'h202), "wrap0");
    step(V(0,1,1,0,0, 1,'h3FE, 1,0,0,0), "wrap1");
    step(V(0,1,1,0,0, 1,'h3FF, 1,0,0,0), "wrap2");
    step(V(0,1,1,0,0, 1,'h000, 1,1,'h13FE,'h3FE), "wrap3");
    step(V(0,1,1,0,0, 1,'h001, 1,1,'h13FF,'h3FF), "wrap4");
    step(V(0,1,1,0,0, 1,'h002, 1,1,'h1000,'h000), "wrap5");
    step(V(0,1,1,0,0, 1,'h003, 1,1,'h1001,'h001), "wrap6");

    // back-to-back redirects: the last one wins
    step(V(0,1,1,1,'h100, 0,0, 1,1,'h1002,'h002), "b2b0");
    step(V(0,1,1,1,'h080, 0,0, 1,0,0,0), "b2b1");
    step(V(0,1,1,0,0, 1,'h080, 1,0,0,0), "b2b2");
    step(V(0,1,1,0,0, 1,'h081, 1,0,0,0), "b2b3");
    step(V(0,1,1,0,0, 1,'h082, 1,1,'h1080,'h080), "b2b4");

    // reset with two entries queued; a stray response right after reset must be ignored
    step(V(0,0,1,0,0, 1,'h083, 1,1,'h1081,'h081), "mrst0");
    step(V(1,0,1,0,0, 0,0, 1,1,'h1081,'h081), "mrst1");
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 16'hDEAD;
    step(V(0,1,1,0,0, 1,0, 1,0,0,0), "mrst2");
    step(V(0,1,1,0,0, 1,1, 1,0,0,0), "mrst3");
    step(V(0,1,1,0,0, 1,2, 1,1,'h1000,0), "mrst4");
    step(V(0,1,1,0,0, 1,3, 1,1,'h1001,1), "mrst5");

    // reset and redirect together: reset wins
    step(V(1,1,1,1,'h155, 0,0, 0,0,0,0), "rr0");
    step(V(0,1,1,0,0, 1,0, 1,0,0,0), "rr1");
    step(V(0,1,1,0,0, 1,1, 1,0,0,0), "rr2");
    step(V(0,1,1,0,0, 1,2, 1,1,'h1000,0), "rr3");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
